arm_alu_seq: RTL and testbench

//  Multi-cycle sequencer that runs WIDTH-bit ARM data-processing ops through one 4-bit ALU slice, one nibble per cycle, LSB first.

---
 rtl/arm_pkg.sv | 95 +++++++++
 rtl/arm_alu_slice.sv | 49 ++++
 rtl/arm_alu_seq.sv | 145 ++++++++++++++
 tb/tb_arm_alu_seq.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// Shared definitions for the nibble-serial ARM ALU sequencer: opcodes, CPSR bit
// positions, condition codes, FSM states and small decode helpers.
package arm_pkg;

    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_EOR = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_RSB = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_ADC = 4'h5;
    localparam logic [3:0] OP_SBC = 4'h6;
    localparam logic [3:0] OP_RSC = 4'h7;
    localparam logic [3:0] OP_TST = 4'h8;
    localparam logic [3:0] OP_TEQ = 4'h9;
    localparam logic [3:0] OP_CMP = 4'hA;
    localparam logic [3:0] OP_CMN = 4'hB;
    localparam logic [3:0] OP_ORR = 4'hC;
    localparam logic [3:0] OP_MOV = 4'hD;
    localparam logic [3:0] OP_BIC = 4'hE;
    localparam logic [3:0] OP_MVN = 4'hF;

    localparam int CPSR_V = 0;
    localparam int CPSR_C = 1;
    localparam int CPSR_Z = 2;
    localparam int CPSR_N = 3;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    function automatic logic is_arith(input logic [3:0] op);
        return op inside {OP_SUB, OP_RSB, OP_ADD, OP_ADC, OP_SBC, OP_RSC, OP_CMP, OP_CMN};
    endfunction

    function automatic logic is_test(input logic [3:0] op);
        return op inside {OP_TST, OP_TEQ, OP_CMP, OP_CMN};
    endfunction

    // Subtract-class ops start with cin=1 so that x + ~y + 1 forms x - y.
    function automatic logic init_cin(input logic [3:0] op, input logic c);
        logic cin;
        cin = 1'b0;
        case (op)
            OP_SUB, OP_RSB, OP_CMP:  cin = 1'b1;
            OP_ADC, OP_SBC, OP_RSC:  cin = c;
            default:                 cin = 1'b0;
        endcase
        return cin;
    endfunction

    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v, pass;
        n = nzcv[CPSR_N];
        z = nzcv[CPSR_Z];
        c = nzcv[CPSR_C];
        v = nzcv[CPSR_V];
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
        return pass;
    endfunction

endpackage

// File: rtl/arm_alu_slice.sv
// Combinational 4-bit ALU slice for the ARM data-processing opcodes.
// Subtract-class ops are formed as op1 + ~op2 + cin, with operands swapped for RSB/RSC.
module arm_alu_slice
    import arm_pkg::*;
(
    input  logic [3:0] op1,
    input  logic [3:0] op2,
    input  logic [3:0] op_sel,
    input  logic       cin,
    output logic [3:0] out,
    output logic       cout,
    output logic       v
);

    logic [3:0] x;
    logic [3:0] y;
    logic [4:0] sum;
    logic       use_add;

    always_comb begin
        x       = op1;
        y       = op2;
        use_add = 1'b0;
        sum     = '0;
        out     = '0;
        cout    = 1'b0;
        v       = 1'b0;
        case (op_sel)
            OP_ADD, OP_ADC, OP_CMN: begin x = op1; y = op2;  use_add = 1'b1; end
            OP_SUB, OP_SBC, OP_CMP: begin x = op1; y = ~op2; use_add = 1'b1; end
            OP_RSB, OP_RSC:         begin x = op2; y = ~op1; use_add = 1'b1; end
            OP_AND, OP_TST:         out = op1 & op2;
            OP_EOR, OP_TEQ:         out = op1 ^ op2;
            OP_ORR:                 out = op1 | op2;
            OP_MOV:                 out = op2;
            OP_BIC:                 out = op1 & ~op2;
            OP_MVN:                 out = ~op2;
            default:                out = '0;
        endcase
        // Overflow only matters for the top nibble; the sequencer ignores it elsewhere.
        if (use_add) begin
            sum  = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
            out  = sum[3:0];
            cout = sum[4];
            v    = (x[3] == y[3]) && (sum[3] != x[3]);
        end
    end

endmodule

// File: rtl/arm_alu_seq.sv
// Nibble-serial ARM data-processing sequencer owning the carry chain and CPSR NZCV.
// Optional macro ARM_ALU_SEQ_COND_EN adds req_cond and conditional execution.
module arm_alu_seq
    import arm_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic             req_s,
`ifdef ARM_ALU_SEQ_COND_EN
    input  logic [3:0]       req_cond,
`endif
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_wb,
    output logic [3:0]       cpsr_q,
    input  logic             cpsr_we,
    input  logic [3:0]       cpsr_wdata
);

    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] idx;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             s_q;
    logic             carry_q;
    logic             zero_q;
    logic [WIDTH-1:0] result_q;
    logic             wb_q;

    logic             accept;
    logic             last;
    logic             cond_ok;
    logic             flag_upd;
    logic [3:0]       flags_next;
    logic [3:0]       slice_out;
    logic             slice_cout;
    logic             slice_v;

    assign req_ready  = (state == IDLE);
    assign rsp_valid  = (state == DONE);
    assign rsp_result = result_q;
    assign rsp_wb     = wb_q;
    assign accept     = req_valid && req_ready;
    assign last       = (idx == LAST_IDX);

`ifdef ARM_ALU_SEQ_COND_EN
    assign cond_ok = cond_pass(req_cond, cpsr_q);
`else
    assign cond_ok = 1'b1;
`endif

    arm_alu_slice u_slice (
        .op1    (a_q[{idx, 2'b00} +: 4]),
        .op2    (b_q[{idx, 2'b00} +: 4]),
        .op_sel (op_q),
        .cin    (carry_q),
        .out    (slice_out),
        .cout   (slice_cout),
        .v      (slice_v)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = cond_ok ? EXEC : DONE;
            EXEC:    if (last) state_next = DONE;
            DONE:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx      <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            s_q      <= 1'b0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b1;
            result_q <= '0;
            wb_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op_q     <= req_op;
                    a_q      <= req_a;
                    b_q      <= req_b;
                    s_q      <= req_s;
                    idx      <= '0;
                    carry_q  <= init_cin(req_op, cpsr_q[CPSR_C]);
                    zero_q   <= 1'b1;
                    result_q <= '0;
                    wb_q     <= cond_ok && !is_test(req_op);
                end
                EXEC: begin
                    result_q[{idx, 2'b00} +: 4] <= slice_out;
                    carry_q <= slice_cout;
                    zero_q  <= zero_q && (slice_out == 4'h0);
                    if (!last) idx <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Flags come from the top nibble on the EXEC->DONE edge; logical ops keep C and V.
    assign flag_upd = (state == EXEC) && last && (s_q || is_test(op_q));

    always_comb begin
        flags_next         = cpsr_q;
        flags_next[CPSR_N] = slice_out[3];
        flags_next[CPSR_Z] = zero_q && (slice_out == 4'h0);
        if (is_arith(op_q)) begin
            flags_next[CPSR_C] = slice_cout;
            flags_next[CPSR_V] = slice_v;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)        cpsr_q <= '0;
        else if (cpsr_we)  cpsr_q <= cpsr_wdata;
        else if (flag_upd) cpsr_q <= flags_next;
    end

endmodule

// File: tb/tb_arm_alu_seq.sv
// Directed self-checking bench for arm_alu_seq (WIDTH=32); define ARM_ALU_SEQ_COND_EN
// to also exercise conditional execution.
module tb_arm_alu_seq;
    import arm_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        req_s;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_wb;
    logic [3:0]  cpsr_q;
    logic        cpsr_we;
    logic [3:0]  cpsr_wdata;
`ifdef ARM_ALU_SEQ_COND_EN
    logic [3:0]  req_cond;
`endif

    int n_cmp;
    int n_fail;

    arm_alu_seq #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_s      (req_s),
`ifdef ARM_ALU_SEQ_COND_EN
        .req_cond   (req_cond),
`endif
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_wb     (rsp_wb),
        .cpsr_q     (cpsr_q),
        .cpsr_we    (cpsr_we),
        .cpsr_wdata (cpsr_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Issues one request, waits (bounded) for the response, then retires it.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic s, output logic [31:0] res, output logic wb, output int lat);
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_s = s;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        res = rsp_result;
        wb  = rsp_wb;
        @(negedge clk); rsp_ready = 1'b1;
        @(posedge clk); #1; rsp_ready = 1'b0;
    endtask

    task automatic write_cpsr(input logic [3:0] val);
        @(negedge clk); cpsr_we = 1'b1; cpsr_wdata = val;
        @(negedge clk); cpsr_we = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_req_ready: got %b expected 1", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        n_cmp++; if (rsp_result !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_result: got %h expected 00000000", rsp_result); end
        n_cmp++; if (rsp_wb !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_wb: got %b expected 0", rsp_wb); end
        n_cmp++; if (cpsr_q !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_cpsr: got %b expected 0000", cpsr_q); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_add();
        logic [31:0] res; logic wb; int lat;
        run_op(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, res, wb, lat);
        n_cmp++; if (lat !== 9) begin n_fail++; $display("[TB] FAIL add_latency: got %0d expected 9", lat); end
        n_cmp++; if (res !== 32'h0) begin n_fail++; $display("[TB] FAIL add_result: got %h expected 00000000", res); end
        n_cmp++; if (wb !== 1'b1) begin n_fail++; $display("[TB] FAIL add_wb: got %b expected 1", wb); end
        n_cmp++; if (cpsr_q !== 4'b0110) begin n_fail++; $display("[TB] FAIL add_nzcv: got %b expected 0110", cpsr_q); end
    endtask

    task automatic test_sub_rsb();
        logic [31:0] res; logic wb; int lat;
        run_op(OP_SUB, 32'h8000_0000, 32'h0000_0001, 1'b1, res, wb, lat);
        n_cmp++; if (res !== 32'h7FFF_FFFF) begin n_fail++; $display("[TB] FAIL sub_result: got %h expected 7fffffff", res); end
        n_cmp++; if (cpsr_q !== 4'b0011) begin n_fail++; $display("[TB] FAIL sub_nzcv: got %b expected 0011", cpsr_q); end
        run_op(OP_RSB, 32'h0000_0001, 32'h0000_0000, 1'b1, res, wb, lat);
        n_cmp++; if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("[TB] FAIL rsb_result: got %h expected ffffffff", res); end
        n_cmp++; if (cpsr_q !== 4'b1000) begin n_fail++; $display("[TB] FAIL rsb_nzcv: got %b expected 1000", cpsr_q); end
    endtask

    task automatic test_compare();
        logic [31:0] res; logic wb; int lat;
        run_op(OP_CMP, 32'd5, 32'd5, 1'b0, res, wb, lat);
        n_cmp++; if (wb !== 1'b0) begin n_fail++; $display("[TB] FAIL cmp_wb: got %b expected 0", wb); end
        n_cmp++; if (cpsr_q !== 4'b0110) begin n_fail++; $display("[TB] FAIL cmp_nzcv: got %b expected 0110", cpsr_q); end
        run_op(OP_ORR, 32'h0000_00F0, 32'h0000_000F, 1'b0, res, wb, lat);
        n_cmp++; if (res !== 32'h0000_00FF) begin n_fail++; $display("[TB] FAIL orr_result: got %h expected 000000ff", res); end
        n_cmp++; if (wb !== 1'b1) begin n_fail++; $display("[TB] FAIL orr_wb: got %b expected 1", wb); end
        n_cmp++; if (cpsr_q !== 4'b0110) begin n_fail++; $display("[TB] FAIL orr_nzcv_kept: got %b expected 0110", cpsr_q); end
    endtask

    task automatic test_cpsr_write();
        logic [31:0] res; logic wb; int lat;
        write_cpsr(4'b0010);
        #1;
        n_cmp++; if (cpsr_q !== 4'b0010) begin n_fail++; $display("[TB] FAIL msr_write: got %b expected 0010", cpsr_q); end
        run_op(OP_ADC, 32'h0000_000F, 32'h0000_0000, 1'b1, res, wb, lat);
        n_cmp++; if (res !== 32'h0000_0010) begin n_fail++; $display("[TB] FAIL adc_result: got %h expected 00000010", res); end
        n_cmp++; if (cpsr_q !== 4'b0000) begin n_fail++; $display("[TB] FAIL adc_nzcv: got %b expected 0000", cpsr_q); end
    endtask

    // cpsr_we is held only across the EXEC->DONE edge, which is the 8th edge after accept.
    task automatic test_same_edge();
        @(negedge clk);
        req_valid = 1'b1; req_op = OP_ADD; req_a = 32'hFFFF_FFFF; req_b = 32'h1; req_s = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk); cpsr_we = 1'b1; cpsr_wdata = 4'b1001;
        @(posedge clk); #1; cpsr_we = 1'b0;
        n_cmp++; if (rsp_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL same_edge_valid: got %b expected 1", rsp_valid); end
        n_cmp++; if (cpsr_q !== 4'b1001) begin n_fail++; $display("[TB] FAIL same_edge_nzcv: got %b expected 1001", cpsr_q); end
        @(negedge clk); rsp_ready = 1'b1;
        @(posedge clk); #1; rsp_ready = 1'b0;
    endtask

    task automatic test_logical_flags();
        logic [31:0] res; logic wb; int lat;
        write_cpsr(4'b0011);
        run_op(OP_MOV, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1, res, wb, lat);
        n_cmp++; if (res !== 32'h0) begin n_fail++; $display("[TB] FAIL mov_result: got %h expected 00000000", res); end
        n_cmp++; if (cpsr_q !== 4'b0111) begin n_fail++; $display("[TB] FAIL mov_nzcv: got %b expected 0111", cpsr_q); end
        run_op(OP_MVN, 32'h1234_5678, 32'h0000_0000, 1'b1, res, wb, lat);
        n_cmp++; if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("[TB] FAIL mvn_result: got %h expected ffffffff", res); end
        n_cmp++; if (cpsr_q !== 4'b1011) begin n_fail++; $display("[TB] FAIL mvn_nzcv: got %b expected 1011", cpsr_q); end
        run_op(OP_BIC, 32'hFF00_FF00, 32'h0F0F_0F0F, 1'b0, res, wb, lat);
        n_cmp++; if (res !== 32'hF000_F000) begin n_fail++; $display("[TB] FAIL bic_result: got %h expected f000f000", res); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res; logic wb; int lat;
        write_cpsr(4'b0000);
        run_op(OP_SBC, 32'd10, 32'd3, 1'b1, res, wb, lat);
        n_cmp++; if (res !== 32'd6) begin n_fail++; $display("[TB] FAIL sbc_result: got %h expected 00000006", res); end
        n_cmp++; if (cpsr_q !== 4'b0010) begin n_fail++; $display("[TB] FAIL sbc_nzcv: got %b expected 0010", cpsr_q); end
        run_op(OP_RSC, 32'd3, 32'd10, 1'b1, res, wb, lat);
        n_cmp++; if (res !== 32'd7) begin n_fail++; $display("[TB] FAIL rsc_result: got %h expected 00000007", res); end
        n_cmp++; if (lat !== 9) begin n_fail++; $display("[TB] FAIL rsc_latency: got %0d expected 9", lat); end
    endtask

    task automatic test_hold();
        int lat;
        @(negedge clk);
        req_valid = 1'b1; req_op = OP_EOR; req_a = 32'h1234_5678; req_b = 32'hFFFF_0000; req_s = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        n_cmp++; if (lat !== 9) begin n_fail++; $display("[TB] FAIL hold_latency: got %0d expected 9", lat); end
        req_valid = 1'b1; req_op = OP_MOV; req_b = 32'hAAAA_AAAA;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_cmp++; if (rsp_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL hold_valid[%0d]: got %b expected 1", i, rsp_valid); end
            n_cmp++; if (rsp_result !== 32'hEDCB_5678) begin n_fail++; $display("[TB] FAIL hold_result[%0d]: got %h expected edcb5678", i, rsp_result); end
            n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL hold_req_ready[%0d]: got %b expected 0", i, req_ready); end
        end
        req_valid = 1'b0;
        @(negedge clk); rsp_ready = 1'b1;
        @(posedge clk); #1; rsp_ready = 1'b0;
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL hold_release: got %b expected 1", req_ready); end
    endtask

    task automatic test_reset_mid();
        write_cpsr(4'b1111);
        @(negedge clk);
        req_valid = 1'b1; req_op = OP_ADD; req_a = 32'h1; req_b = 32'h2; req_s = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_req_ready: got %b expected 1", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_rsp_valid: got %b expected 0", rsp_valid); end
        n_cmp++; if (cpsr_q !== 4'b0000) begin n_fail++; $display("[TB] FAIL midrst_cpsr: got %b expected 0000", cpsr_q); end
        n_cmp++; if (rsp_result !== 32'h0) begin n_fail++; $display("[TB] FAIL midrst_result: got %h expected 00000000", rsp_result); end
        @(negedge clk); rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_abandon: got %b expected 0", rsp_valid); end
        n_cmp++; if (cpsr_q !== 4'b0000) begin n_fail++; $display("[TB] FAIL midrst_no_flags: got %b expected 0000", cpsr_q); end
    endtask

`ifdef ARM_ALU_SEQ_COND_EN
    task automatic test_cond();
        logic [31:0] res; logic wb; int lat;
        write_cpsr(4'b0000);
        req_cond = COND_EQ;
        run_op(OP_ADD, 32'hFFFF_FFFF, 32'h1, 1'b1, res, wb, lat);
        n_cmp++; if (lat !== 1) begin n_fail++; $display("[TB] FAIL cond_fail_latency: got %0d expected 1", lat); end
        n_cmp++; if (wb !== 1'b0) begin n_fail++; $display("[TB] FAIL cond_fail_wb: got %b expected 0", wb); end
        n_cmp++; if (res !== 32'h0) begin n_fail++; $display("[TB] FAIL cond_fail_result: got %h expected 00000000", res); end
        n_cmp++; if (cpsr_q !== 4'b0000) begin n_fail++; $display("[TB] FAIL cond_fail_nzcv: got %b expected 0000", cpsr_q); end
        req_cond = COND_AL;
        run_op(OP_ADD, 32'h1, 32'h1, 1'b0, res, wb, lat);
        n_cmp++; if (lat !== 9) begin n_fail++; $display("[TB] FAIL cond_al_latency: got %0d expected 9", lat); end
        n_cmp++; if (res !== 32'h2) begin n_fail++; $display("[TB] FAIL cond_al_result: got %h expected 00000002", res); end
        n_cmp++; if (wb !== 1'b1) begin n_fail++; $display("[TB] FAIL cond_al_wb: got %b expected 1", wb); end
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_op = OP_AND;
        req_a = '0;
        req_b = '0;
        req_s = 1'b0;
        rsp_ready = 1'b0;
        cpsr_we = 1'b0;
        cpsr_wdata = 4'b0000;
`ifdef ARM_ALU_SEQ_COND_EN
        req_cond = COND_AL;
`endif
        $display("[TB] starting arm_alu_seq directed tests");
        test_reset();
        test_add();
        test_sub_rsb();
        test_compare();
        test_cpsr_write();
        test_same_edge();
        test_logical_flags();
        test_back_to_back();
        test_hold();
        test_reset_mid();
`ifdef ARM_ALU_SEQ_COND_EN
        test_cond();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
